// File: rtl/arduino_note_tx_pkg.sv
// Shared state codes and character constants for the Arduino note transmitter.
// Frame length depends on ARDUINO_TX_PARITY_EN (8E1 when defined, 8N1 otherwise).
package arduino_note_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  localparam logic [7:0] ASCII_BASE   = 8'h30;
  localparam logic [7:0] SILENCE_CODE = 8'h30;
  localparam int         DATA_BITS    = 8;
`ifdef ARDUINO_TX_PARITY_EN
  localparam int         FRAME_BITS   = 11;
`else
  localparam int         FRAME_BITS   = 10;
`endif

  // Note index 0..6 maps to the ASCII digits '1'..'7'.
  function automatic logic [7:0] note_ascii(input logic [2:0] idx);
    return ASCII_BASE + {5'd0, idx} + 8'd1;
  endfunction

endpackage

// File: rtl/arduino_note_tx_encoder.sv
// One-hot note to ASCII digit; flags zero or multiple set bits as invalid.
module arduino_note_encoder
  import arduino_note_tx_pkg::*;
(
  input  logic [6:0] nota,
  output logic [7:0] code,
  output logic       invalid
);

  logic [2:0] ones;
  logic [2:0] idx;

  always_comb begin
    ones = '0;
    idx  = '0;
    for (int i = 0; i < 7; i++) begin
      if (nota[i]) begin
        ones = ones + 3'd1;
        idx  = 3'(i);
      end
    end
    invalid = (ones != 3'd1);
    code    = note_ascii(idx);
  end

endmodule

// File: rtl/arduino_note_tx.sv
// Serial 8N1 (8E1 with ARDUINO_TX_PARITY_EN) transmitter of ASCII note digits,
// with a one-deep pending buffer for a request arriving mid-frame.
module arduino_note_tx
  import arduino_note_tx_pkg::*;
#(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 9600
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       send,
  input  logic [6:0] nota,
  output logic       tx,
  output logic       busy,
  output logic       done,
  output logic       overrun,
  output logic [2:0] db_estado
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_DONE = CW'(CLKS_PER_BIT - 2);

  tx_state_e   state;
  logic [CW-1:0] cnt;
  logic [2:0]  bit_idx;
  logic [2:0]  nxt_idx;
  logic [7:0]  shreg;
  logic [7:0]  pend;
  logic        pend_valid;
  logic [7:0]  enc_code;
  logic        enc_invalid;
  logic [7:0]  enc_byte;
  logic        cnt_last;
  logic        stop_last;

  arduino_note_encoder u_enc (
    .nota    (nota),
    .code    (enc_code),
    .invalid (enc_invalid)
  );

  assign enc_byte  = enc_invalid ? SILENCE_CODE : enc_code;
  assign cnt_last  = (cnt == CNT_LAST);
  assign stop_last = (state == ST_STOP) && cnt_last;
  assign nxt_idx   = bit_idx + 3'd1;
  assign busy      = (state != ST_IDLE) | pend_valid;
  assign db_estado = state;

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      tx         <= 1'b1;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      pend       <= '0;
      pend_valid <= 1'b0;
      done       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      done    <= 1'b0;
      overrun <= 1'b0;

      // Mid-frame request: buffer once, drop further ones. A request on the
      // final stop cycle with nothing pending is loaded straight into the frame.
      if (send && state != ST_IDLE) begin
        if (pend_valid)
          overrun <= 1'b1;
        else if (!stop_last) begin
          pend       <= enc_byte;
          pend_valid <= 1'b1;
        end
      end

      case (state)
        ST_IDLE: begin
          if (send) begin
            shreg <= enc_byte;
            state <= ST_START;
            tx    <= 1'b0;
            cnt   <= '0;
          end
        end
        ST_START: begin
          if (cnt_last) begin
            state   <= ST_DATA;
            cnt     <= '0;
            bit_idx <= '0;
            tx      <= shreg[0];
          end else
            cnt <= cnt + 1'b1;
        end
        ST_DATA: begin
          if (cnt_last) begin
            cnt <= '0;
            if (bit_idx == 3'd7) begin
`ifdef ARDUINO_TX_PARITY_EN
              state <= ST_PARITY;
              tx    <= ^shreg;
`else
              state <= ST_STOP;
              tx    <= 1'b1;
`endif
            end else begin
              bit_idx <= nxt_idx;
              tx      <= shreg[nxt_idx];
            end
          end else
            cnt <= cnt + 1'b1;
        end
`ifdef ARDUINO_TX_PARITY_EN
        ST_PARITY: begin
          if (cnt_last) begin
            state <= ST_STOP;
            cnt   <= '0;
            tx    <= 1'b1;
          end else
            cnt <= cnt + 1'b1;
        end
`endif
        ST_STOP: begin
          if (cnt == CNT_DONE)
            done <= 1'b1;
          if (cnt_last) begin
            cnt <= '0;
            if (pend_valid) begin
              shreg      <= pend;
              pend_valid <= 1'b0;
              state      <= ST_START;
              tx         <= 1'b0;
            end else if (send) begin
              shreg <= enc_byte;
              state <= ST_START;
              tx    <= 1'b0;
            end else
              state <= ST_IDLE;
          end else
            cnt <= cnt + 1'b1;
        end
        default: begin
          state <= ST_IDLE;
          tx    <= 1'b1;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/arduino_note_tx.md
Name: arduino_note_tx

Overview:
Serial transmitter that drives the game's arduino_out line toward the external Arduino sound board. It sits downstream of the game datapath/control pair and consumes the 7-bit one-hot note (memory/jogada value) plus a one-cycle send strobe. It encodes the note to an ASCII digit and shifts it out as an asynchronous 8N1 frame. A one-deep pending buffer absorbs a back-to-back request.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz
BAUD, 9600, line rate; CLKS_PER_BIT = CLK_FREQ/BAUD (integer division, must be >= 2)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
send  in  1  one-cycle request strobe (activateArduino)
nota  in  7  one-hot note code (bit i = note i+1)
tx  out  1  serial line to Arduino; idle high (arduino_out)
busy  out  1  high while a frame is in progress or pending
done  out  1  one-cycle pulse when the last stop bit completes
overrun  out  1  one-cycle pulse when a request is dropped
db_estado  out  3  current FSM state code (debug)

Behaviour:
- Clock is clock; reset is synchronous and active-high. On reset: tx=1, busy=0, done=0, overrun=0, state IDLE, pending buffer empty, counters 0. Reset mid-frame aborts immediately; tx returns high on the next edge.
- Encoding (at request capture): exactly one bit i set -> byte = 8'h30 + (i+1) ('1'..'7'); zero or multiple bits set -> 8'h30 ('0' = silence).
- FSM states/codes: IDLE=0, START=1, DATA=2, PARITY=3 (feature only), STOP=4.
- IDLE: send=1 -> latch byte, go START next edge; tx low from cycle N+1 (one-cycle latency).
- START: tx=0 for CLKS_PER_BIT cycles -> DATA.
- DATA: 8 bits LSB first, each CLKS_PER_BIT cycles; bit index 0..7, after bit 7 -> STOP (or PARITY).
- STOP: tx=1 for CLKS_PER_BIT cycles; on final cycle done=1; then START if pending valid (pending moves to shift register, no idle gap), else IDLE.
- Baud counter counts 0..CLKS_PER_BIT-1, clears on every state change; width $clog2(CLKS_PER_BIT).
- send while busy and pending empty -> encode and store in pending. send while pending full -> request dropped, overrun=1 for that cycle, pending unchanged.
- send on the same cycle as done with pending empty -> stored in pending, transmitted immediately (no drop).
- busy = (state != IDLE) | pending_valid; busy rises the cycle after the accepted send.
- nota sampled only at the send cycle; changes afterward have no effect.

Optional Feature:
Macro ARDUINO_TX_PARITY_EN. Defined: frame is 8E1; PARITY state after bit 7 drives even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles, frame = 11 bit-times. Undefined: PARITY state and logic absent, frame 8N1 = 10 bit-times, code 3 never appears.

Decomposition:
- Shared package/include: state codes (IDLE..STOP), ASCII_BASE = 8'h30, SILENCE_CODE = 8'h30, frame-length constants.
- One sub-module: arduino_note_encoder (combinational one-hot -> ASCII byte, with invalid detection), instantiated once, shared by the direct and pending capture paths.

Test Plan:
- CLK_FREQ=1000, BAUD=100 (10 clk/bit); reset, then send with nota=7'b0000100 -> tx low at N+1 for 10 clks, data 0x33 LSB first (1,1,0,0,1,1,0,0), stop high; done at N+100; busy low N+101.
- nota=7'b0000000 and nota=7'b0010010 -> byte 0x30 on the line both times.
- send, second send 20 clks later (nota=7'b1000000), third send 30 clks later -> frames 1 and 0x37 back-to-back with no idle gap; third request dropped, overrun pulses exactly once.
- send coincident with done, pending empty -> next START begins the cycle after done; no overrun.
- reset asserted at clk 45 of a frame -> tx=1, busy=0, db_estado=0 next edge; fresh send then transmits correctly.
- ARDUINO_TX_PARITY_EN defined, nota=7'b0000001 (0x31, three ones) -> parity bit 1, done at N+110.
